cache_refill_ctrl: RTL and testbench

- Miss-side engine of the 4-way set-associative cache; it serves the miss requests raised by the tag-compare/lookup path.
- On an accepted miss it first writes back the dirty victim line word-by-word to next-level memory. It then fetches the missing line word-by-word, writes it into the chosen way and finally updates that way's metadata.
- It sits between the cache array/lookup logic and the memory bus.

---
 rtl/cache_pkg.sv | 35 +++
 rtl/cache_refill_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache geometry, metadata layout and refill FSM states
// for the 4-way set-associative cache and its miss engine.
package cache_pkg;

  localparam int CACHE_LINES     = 256;
  localparam int LINE_SIZE_BYTES = 64;
  localparam int TAG_BITS        = 18;
  localparam int DATA_WIDTH      = 32;
  localparam int WAYS            = 4;

  localparam int INDEX_BITS = $clog2(CACHE_LINES);
  localparam int WAY_BITS   = $clog2(WAYS);
  localparam int WORDS      = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
  localparam int CNT_BITS   = $clog2(WORDS);
  localparam int ADDR_BITS  = 32;

  localparam logic [CNT_BITS-1:0] LAST_WORD = CNT_BITS'(WORDS - 1);

  typedef struct packed {
    logic                valid;
    logic [WAY_BITS-1:0] lru;
    logic                dirty;
    logic [TAG_BITS-1:0] tag;
  } meta_t;

  typedef enum logic [2:0] {
    IDLE,
    WB_RD,
    WB_SEND,
    FILL_REQ,
    FILL_WAIT,
    META
  } refill_state_e;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Miss engine: writes back a dirty victim line, fetches the
// missing line word by word, then commits the way's metadata.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_miss_valid,
  output logic                  o_miss_ready,
  input  logic [TAG_BITS-1:0]   i_miss_tag,
  input  logic [INDEX_BITS-1:0] i_miss_index,
  input  logic [WAY_BITS-1:0]   i_victim_way,
  input  logic                  i_victim_dirty,
  input  logic [TAG_BITS-1:0]   i_victim_tag,
  output logic                  o_arr_rd_en,
  output logic [INDEX_BITS-1:0] o_arr_rd_index,
  output logic [WAY_BITS-1:0]   o_arr_rd_way,
  output logic [CNT_BITS-1:0]   o_arr_rd_word,
  input  logic [DATA_WIDTH-1:0] i_arr_rd_data,
  output logic                  o_arr_wr_en,
  output logic [INDEX_BITS-1:0] o_arr_wr_index,
  output logic [WAY_BITS-1:0]   o_arr_wr_way,
  output logic [CNT_BITS-1:0]   o_arr_wr_word,
  output logic [DATA_WIDTH-1:0] o_arr_wr_data,
  output logic                  o_arr_meta_we,
  output logic [TAG_BITS-1:0]   o_arr_meta_tag,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic                  o_mem_req_we,
  output logic [ADDR_BITS-1:0]  o_mem_req_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_rdata_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_busy,
  output logic                  o_done
);

  refill_state_e         state;
  logic [CNT_BITS-1:0]   cnt;
  logic [CNT_BITS-1:0]   cnt_inc;
  logic [TAG_BITS-1:0]   tag_q;
  logic [TAG_BITS-1:0]   vtag_q;
  logic [INDEX_BITS-1:0] idx_q;
  logic [WAY_BITS-1:0]   way_q;
  logic                  wb_first;
  logic [DATA_WIDTH-1:0] wdata_q;

  assign cnt_inc = cnt + CNT_BITS'(1);

  assign o_arr_wr_en    = (state == FILL_WAIT) & i_mem_rdata_valid;
  assign o_arr_wr_index = idx_q;
  assign o_arr_wr_way   = way_q;
  assign o_arr_wr_word  = cnt;
  assign o_arr_wr_data  = o_arr_wr_en ? i_mem_rdata : '0;
  assign o_arr_meta_tag = tag_q;

  // Array data lands in the first WB_SEND cycle; forward it,
  // then hold the captured copy while memory stalls.
  assign o_mem_wdata = (state == WB_SEND && wb_first) ?
                       i_arr_rd_data : wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      tag_q           <= '0;
      vtag_q          <= '0;
      idx_q           <= '0;
      way_q           <= '0;
      wb_first        <= 1'b0;
      wdata_q         <= '0;
      o_miss_ready    <= 1'b1;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_arr_meta_we   <= 1'b0;
      o_arr_rd_en     <= 1'b0;
      o_arr_rd_index  <= '0;
      o_arr_rd_way    <= '0;
      o_arr_rd_word   <= '0;
      o_mem_req_valid <= 1'b0;
      o_mem_req_we    <= 1'b0;
      o_mem_req_addr  <= '0;
    end else begin
      o_done        <= 1'b0;
      o_arr_meta_we <= 1'b0;
      o_arr_rd_en   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_miss_valid) begin
            tag_q        <= i_miss_tag;
            vtag_q       <= i_victim_tag;
            idx_q        <= i_miss_index;
            way_q        <= i_victim_way;
            cnt          <= '0;
            o_miss_ready <= 1'b0;
            o_busy       <= 1'b1;
            if (i_victim_dirty) begin
              state          <= WB_RD;
              o_arr_rd_en    <= 1'b1;
              o_arr_rd_index <= i_miss_index;
              o_arr_rd_way   <= i_victim_way;
              o_arr_rd_word  <= '0;
            end else begin
              state           <= FILL_REQ;
              o_mem_req_valid <= 1'b1;
              o_mem_req_we    <= 1'b0;
              o_mem_req_addr  <= {i_miss_tag, i_miss_index,
                                  {CNT_BITS{1'b0}}, 2'b00};
            end
          end
        end
        WB_RD: begin
          state           <= WB_SEND;
          wb_first        <= 1'b1;
          o_mem_req_valid <= 1'b1;
          o_mem_req_we    <= 1'b1;
          o_mem_req_addr  <= {vtag_q, idx_q, cnt, 2'b00};
        end
        WB_SEND: begin
          wb_first <= 1'b0;
          if (wb_first) wdata_q <= i_arr_rd_data;
          if (i_mem_req_ready) begin
            if (cnt == LAST_WORD) begin
              cnt            <= '0;
              state          <= FILL_REQ;
              o_mem_req_we   <= 1'b0;
              o_mem_req_addr <= {tag_q, idx_q,
                                 {CNT_BITS{1'b0}}, 2'b00};
            end else begin
              cnt             <= cnt_inc;
              state           <= WB_RD;
              o_mem_req_valid <= 1'b0;
              o_mem_req_we    <= 1'b0;
              o_arr_rd_en     <= 1'b1;
              o_arr_rd_word   <= cnt_inc;
            end
          end
        end
        FILL_REQ: begin
          if (i_mem_req_ready) begin
            state           <= FILL_WAIT;
            o_mem_req_valid <= 1'b0;
          end
        end
        FILL_WAIT: begin
          if (i_mem_rdata_valid) begin
            if (cnt == LAST_WORD) begin
              state         <= META;
              o_arr_meta_we <= 1'b1;
              o_done        <= 1'b1;
            end else begin
              cnt             <= cnt_inc;
              state           <= FILL_REQ;
              o_mem_req_valid <= 1'b1;
              o_mem_req_we    <= 1'b0;
              o_mem_req_addr  <= {tag_q, idx_q, cnt_inc, 2'b00};
            end
          end
        end
        META: begin
          state        <= IDLE;
          cnt          <= '0;
          o_miss_ready <= 1'b1;
          o_busy       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: memory and array models
// feed a scoreboard of expected requests, writes and metadata.
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  i_miss_valid;
  logic                  o_miss_ready;
  logic [TAG_BITS-1:0]   i_miss_tag;
  logic [INDEX_BITS-1:0] i_miss_index;
  logic [WAY_BITS-1:0]   i_victim_way;
  logic                  i_victim_dirty;
  logic [TAG_BITS-1:0]   i_victim_tag;
  logic                  o_arr_rd_en;
  logic [INDEX_BITS-1:0] o_arr_rd_index;
  logic [WAY_BITS-1:0]   o_arr_rd_way;
  logic [CNT_BITS-1:0]   o_arr_rd_word;
  logic [DATA_WIDTH-1:0] i_arr_rd_data;
  logic                  o_arr_wr_en;
  logic [INDEX_BITS-1:0] o_arr_wr_index;
  logic [WAY_BITS-1:0]   o_arr_wr_way;
  logic [CNT_BITS-1:0]   o_arr_wr_word;
  logic [DATA_WIDTH-1:0] o_arr_wr_data;
  logic                  o_arr_meta_we;
  logic [TAG_BITS-1:0]   o_arr_meta_tag;
  logic                  o_mem_req_valid;
  logic                  mem_ready;
  logic                  o_mem_req_we;
  logic [31:0]           o_mem_req_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic                  rsp_valid;
  logic                  stray_valid;
  logic                  i_mem_rdata_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  o_busy;
  logic                  o_done;

  assign i_mem_rdata_valid = rsp_valid | stray_valid;

  cache_refill_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .i_miss_valid      (i_miss_valid),
    .o_miss_ready      (o_miss_ready),
    .i_miss_tag        (i_miss_tag),
    .i_miss_index      (i_miss_index),
    .i_victim_way      (i_victim_way),
    .i_victim_dirty    (i_victim_dirty),
    .i_victim_tag      (i_victim_tag),
    .o_arr_rd_en       (o_arr_rd_en),
    .o_arr_rd_index    (o_arr_rd_index),
    .o_arr_rd_way      (o_arr_rd_way),
    .o_arr_rd_word     (o_arr_rd_word),
    .i_arr_rd_data     (i_arr_rd_data),
    .o_arr_wr_en       (o_arr_wr_en),
    .o_arr_wr_index    (o_arr_wr_index),
    .o_arr_wr_way      (o_arr_wr_way),
    .o_arr_wr_word     (o_arr_wr_word),
    .o_arr_wr_data     (o_arr_wr_data),
    .o_arr_meta_we     (o_arr_meta_we),
    .o_arr_meta_tag    (o_arr_meta_tag),
    .o_mem_req_valid   (o_mem_req_valid),
    .i_mem_req_ready   (mem_ready),
    .o_mem_req_we      (o_mem_req_we),
    .o_mem_req_addr    (o_mem_req_addr),
    .o_mem_wdata       (o_mem_wdata),
    .i_mem_rdata_valid (i_mem_rdata_valid),
    .i_mem_rdata       (rsp_data),
    .o_busy            (o_busy),
    .o_done            (o_done)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [13:0] loc;
    logic [31:0] data;
  } wr_t;

  req_t        exp_req[$];
  wr_t         exp_wr[$];
  logic [17:0] exp_meta[$];

  logic [31:0] arr [16384];
  logic [31:0] fill_base;
  int          rdy_lat;
  int          rsp_lat;
  int          n_chk;
  int          n_fail;

  logic        hold_v;
  logic        hold_we;
  logic [31:0] hold_addr;
  logic [31:0] hold_wd;

  // Memory: ready after rdy_lat stalled cycles, read data
  // rsp_lat cycles after acceptance, data = fill_base + word.
  initial begin
    int          vcnt;
    int          cd;
    logic [31:0] ra;
    logic        acc;
    logic        acc_we;
    logic [31:0] acc_addr;
    vcnt = 0;
    cd = 0;
    ra = '0;
    mem_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data = '0;
    forever begin
      @(negedge clk);
      acc = o_mem_req_valid && mem_ready && rst;
      acc_we = o_mem_req_we;
      acc_addr = o_mem_req_addr;
      if (!rst) vcnt = 0;
      else if (o_mem_req_valid && !mem_ready) vcnt++;
      @(posedge clk);
      #1;
      rsp_valid = 1'b0;
      if (acc) begin
        vcnt = 0;
        if (!acc_we) begin
          cd = rsp_lat;
          ra = acc_addr;
        end
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          rsp_valid = 1'b1;
          rsp_data = fill_base + 32'(ra[5:2]);
        end
      end
      mem_ready = (rdy_lat == 0) ||
                  (o_mem_req_valid && vcnt >= rdy_lat);
    end
  end

  // Cache data array: one-cycle read latency, garbage otherwise.
  initial begin
    logic        en;
    logic [13:0] loc;
    i_arr_rd_data = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      en = o_arr_rd_en;
      loc = {o_arr_rd_way, o_arr_rd_index, o_arr_rd_word};
      @(posedge clk);
      #1;
      i_arr_rd_data = en ? arr[loc] : 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    req_t        r;
    wr_t         w;
    logic [17:0] m;
    if (!rst) begin
      hold_v = 1'b0;
    end else begin
      chk("ready_busy", 64'(o_miss_ready), 64'(!o_busy));
      if (hold_v) begin
        chk("hold_valid", 64'(o_mem_req_valid), 64'(1'b1));
        chk("hold_we", 64'(o_mem_req_we), 64'(hold_we));
        chk("hold_addr", 64'(o_mem_req_addr), 64'(hold_addr));
        chk("hold_wdata", 64'(o_mem_wdata), 64'(hold_wd));
      end
      hold_v = o_mem_req_valid && !mem_ready;
      hold_we = o_mem_req_we;
      hold_addr = o_mem_req_addr;
      hold_wd = o_mem_wdata;
      if (o_mem_req_valid && mem_ready) begin
        chk("req_expected", 64'(exp_req.size() > 0), 64'(1'b1));
        if (exp_req.size() > 0) begin
          r = exp_req.pop_front();
          chk("req_we", 64'(o_mem_req_we), 64'(r.we));
          chk("req_addr", 64'(o_mem_req_addr), 64'(r.addr));
          if (r.we) chk("req_wdata", 64'(o_mem_wdata), 64'(r.wdata));
        end
      end
      if (o_arr_wr_en) begin
        chk("wr_expected", 64'(exp_wr.size() > 0), 64'(1'b1));
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          chk("wr_loc", 64'({o_arr_wr_way, o_arr_wr_index,
                             o_arr_wr_word}), 64'(w.loc));
          chk("wr_data", 64'(o_arr_wr_data), 64'(w.data));
        end
      end
      if (o_arr_meta_we || o_done) begin
        chk("meta_done_pair", 64'(o_arr_meta_we), 64'(o_done));
        chk("meta_expected", 64'(exp_meta.size() > 0), 64'(1'b1));
        if (exp_meta.size() > 0) begin
          m = exp_meta.pop_front();
          chk("meta_tag", 64'(o_arr_meta_tag), 64'(m));
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic drive_miss(input logic [17:0] tag,
                            input logic [7:0]  idx,
                            input logic [1:0]  way,
                            input logic        dirty,
                            input logic [17:0] vtag);
    req_t r;
    wr_t  w;
    i_miss_valid = 1'b1;
    i_miss_tag = tag;
    i_miss_index = idx;
    i_victim_way = way;
    i_victim_dirty = dirty;
    i_victim_tag = vtag;
    if (dirty) begin
      for (int k = 0; k < 16; k++) begin
        r.we = 1'b1;
        r.addr = {vtag, idx, k[3:0], 2'b00};
        r.wdata = arr[{way, idx, k[3:0]}];
        exp_req.push_back(r);
      end
    end
    for (int k = 0; k < 16; k++) begin
      r.we = 1'b0;
      r.addr = {tag, idx, k[3:0], 2'b00};
      r.wdata = '0;
      exp_req.push_back(r);
      w.loc = {way, idx, k[3:0]};
      w.data = fill_base + 32'(k);
      exp_wr.push_back(w);
    end
    exp_meta.push_back(tag);
  endtask

  task automatic wait_accept(input string tag);
    int k;
    k = 0;
    while (!o_miss_ready && k < 1000) begin
      tick();
      k++;
    end
    chk({tag, "_accept"}, 64'(o_miss_ready), 64'(1'b1));
  endtask

  task automatic wait_done(input string tag, input int lat,
                           input int k0);
    int k;
    bit seen;
    k = k0;
    seen = 1'b0;
    while (!seen && k < 2000) begin
      tick();
      k++;
      i_miss_valid = 1'b0;
      seen = o_done;
    end
    chk({tag, "_latency"}, 64'(k), 64'(lat));
    chk({tag, "_drained"},
        64'(exp_req.size() + exp_wr.size() + exp_meta.size()), 64'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"},
        64'({o_miss_ready, o_busy, o_done, o_arr_meta_we,
             o_mem_req_valid, o_mem_req_we, o_arr_rd_en,
             o_arr_wr_en}), 64'(8'b1000_0000));
    chk({tag, "_addr"}, 64'(o_mem_req_addr), 64'(0));
    chk({tag, "_wdata"}, 64'(o_mem_wdata), 64'(0));
    chk({tag, "_wr_data"}, 64'(o_arr_wr_data), 64'(0));
  endtask

  initial begin
    int k;
    int bad;
    n_chk = 0;
    n_fail = 0;
    hold_v = 1'b0;
    hold_we = 1'b0;
    hold_addr = '0;
    hold_wd = '0;
    rdy_lat = 0;
    rsp_lat = 1;
    fill_base = 32'hA000_0000;
    stray_valid = 1'b0;
    i_miss_valid = 1'b0;
    i_miss_tag = '0;
    i_miss_index = '0;
    i_victim_way = '0;
    i_victim_dirty = 1'b0;
    i_victim_tag = '0;
    for (int i = 0; i < 16384; i++) arr[i] = '0;
    for (int i = 0; i < 16; i++) begin
      arr[{2'd1, 8'h17, i[3:0]}] = 32'hB0 + 32'(i);
      arr[{2'd3, 8'hC3, i[3:0]}] = 32'h7700_0000 + 32'(i);
    end
    rst = 1'b0;
    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();

    // Clean miss, zero-wait memory.
    drive_miss(18'h2A5F3, 8'h17, 2'd2, 1'b0, 18'h3FFFF);
    wait_accept("clean");
    wait_done("clean", 33, 0);
    tick();

    // Dirty miss: write back victim words, then refill.
    fill_base = 32'hC000_0000;
    drive_miss(18'h3C0DE, 8'h17, 2'd1, 1'b1, 18'h00001);
    wait_accept("dirty");
    wait_done("dirty", 65, 0);
    tick();

    // Dirty miss with 3-cycle ready stalls and 5-cycle reads.
    rdy_lat = 3;
    rsp_lat = 5;
    fill_base = 32'h1100_0000;
    drive_miss(18'h155AA, 8'hC3, 2'd3, 1'b1, 18'h2B0B0);
    wait_accept("bp");
    wait_done("bp", 225, 0);
    tick();
    rdy_lat = 0;
    rsp_lat = 1;

    // A second miss arrives while busy and must wait.
    fill_base = 32'h2200_0000;
    drive_miss(18'h01234, 8'h05, 2'd0, 1'b0, 18'h0);
    wait_accept("busy_a");
    tick();
    drive_miss(18'h04321, 8'h06, 2'd1, 1'b0, 18'h0);
    k = 1;
    bad = o_miss_ready ? 1 : 0;
    while (!o_done && k < 1000) begin
      tick();
      k++;
      if (o_miss_ready) bad++;
    end
    chk("busy_a_latency", 64'(k), 64'(33));
    chk("busy_ready_low", 64'(bad), 64'(0));
    tick();
    chk("busy_b_ready", 64'(o_miss_ready), 64'(1'b1));
    wait_done("busy_b", 33, 0);
    tick();

    // Reset while word 7 of a fill is being requested.
    fill_base = 32'h5000_0000;
    drive_miss(18'h0BEEF, 8'h40, 2'd1, 1'b0, 18'h0);
    wait_accept("rst");
    k = 0;
    while (exp_wr.size() > 9 && k < 200) begin
      tick();
      k++;
      i_miss_valid = 1'b0;
    end
    tick();
    chk("rst_midfill_word", 64'(o_mem_req_addr[5:2]), 64'(7));
    #1;
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    exp_req.delete();
    exp_wr.delete();
    exp_meta.delete();
    tick();
    chk_reset_outputs("rst_hold");
    tick();
    rst = 1'b1;
    tick();
    stray_valid = 1'b1;
    #1;
    chk("stray_after_rst_wr", 64'(o_arr_wr_en), 64'(1'b0));
    tick();
    stray_valid = 1'b0;
    chk_reset_outputs("rst_post");
    fill_base = 32'h6000_0000;
    drive_miss(18'h0CAFE, 8'h41, 2'd2, 1'b0, 18'h0);
    wait_accept("post_rst");
    wait_done("post_rst", 33, 0);
    tick();

    // Spurious responses in IDLE and while a fill request stalls.
    rdy_lat = 3;
    stray_valid = 1'b1;
    #1;
    chk("stray_idle_wr", 64'(o_arr_wr_en), 64'(1'b0));
    tick();
    stray_valid = 1'b0;
    fill_base = 32'h7000_0000;
    drive_miss(18'h3A5A5, 8'hFF, 2'd3, 1'b0, 18'h0);
    wait_accept("spur");
    tick();
    i_miss_valid = 1'b0;
    stray_valid = 1'b1;
    #1;
    chk("stray_fillreq_wr", 64'(o_arr_wr_en), 64'(1'b0));
    tick();
    stray_valid = 1'b0;
    wait_done("spur", 81, 2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
